mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter for the single-port `MEMORY` between the `cpu` core and a DMA requester (program loader / video fetch). It owns the memory address, write-data and write-enable lines and stalls the CPU through `cpu_rdy` while DMA holds the bus. DMA tenure is capped at `BURST_MAX` consecutive cycles, after which the CPU is guaranteed one bus cycle. CPU multi-cycle sequences can be kept atomic with `cpu_lock`.

## Interface
- `ADDR_W`, 16: memory address width.
- `DATA_W`, 8: memory data width.
- `BURST_MAX`, 4: maximum consecutive DMA-owned cycles; legal range ≥1 (0 is illegal, rejected by elaboration assertion).

- `CLK` in 1: system clock; all state updates on the rising edge.
- `R_N` in 1: reset, asynchronous, active-low.
- `cpu_addr` in ADDR_W: CPU address (the core's `addr_bus`).
- `cpu_wdata` in DATA_W: CPU write data (the core's `data_in`).
- `cpu_we` in 1: CPU write strobe.
- `cpu_lock` in 1: CPU forbids handover at the next edge (e.g. during carry-out/write sequences).
- `cpu_rdy` out 1: CPU owns the bus this cycle. The core gates every register enable with it.
- `cpu_rdata` out DATA_W: read data to the CPU, equal to `mem_rdata`.
- `dma_req` in 1: DMA request, held high for as long as transfers are wanted.
- `dma_addr` in ADDR_W: DMA address.
- `dma_wdata` in DATA_W: DMA write data.
- `dma_we` in 1: DMA write strobe.
- `dma_gnt` out 1: DMA owns the bus this cycle.
- `dma_rdata` out DATA_W: read data to DMA, equal to `mem_rdata`.
- `mem_addr` out ADDR_W: to `MEMORY.Address`.
- `mem_wdata` out DATA_W: to `MEMORY.DataIn`.
- `mem_we` out 1: to `MEMORY.WE`.
- `mem_rdata` in DATA_W: from `MEMORY.DataOut`.

## Operation
- **State register**: one-hot, with states ST_CPU (001), ST_DMA (010), ST_HOLD (100). There is also a burst counter `bcnt` of width $clog2(BURST_MAX+1).
- **Bus ownership**:
  - CPU owns the bus in ST_CPU and ST_HOLD.
  - DMA owns the bus in ST_DMA.
  - `cpu_rdy = ~st[1]` and `dma_gnt = st[1]`, both decoded from registered state (no combinational path from requests).
- **Bus mux (combinational)**:
  - When the CPU owns the bus, the `mem_*` outputs carry the `cpu_*` inputs.
  - When DMA owns the bus, they carry `dma_*`.
  - `mem_we = cpu_rdy & cpu_we | dma_gnt & dma_req & dma_we`. A DMA write in the cycle `dma_req` drops is suppressed.
- **Transitions**:
  - ST_CPU: if `dma_req & ~cpu_lock`, go to ST_DMA and set `bcnt` to 1. Otherwise stay.
  - ST_DMA:
    - if `~dma_req`, go to ST_CPU and clear `bcnt`;
    - else if `bcnt == BURST_MAX`, go to ST_HOLD and clear `bcnt`;
    - else stay and increment `bcnt`.
  - ST_HOLD: if `dma_req & ~cpu_lock`, go to ST_DMA and set `bcnt` to 1. Otherwise go to ST_CPU.
- **`cpu_lock` scope**: only blocks entry into ST_DMA. It is ignored inside ST_DMA, because the CPU is stalled there.
- **Read data**: `cpu_rdata` and `dma_rdata` are both wired to `mem_rdata`. Each is meaningful only while its owner flag is high.

## Timing
- **Reset** (asynchronous assertion of `R_N` low):
  - state goes to ST_CPU and `bcnt` to 0, giving `cpu_rdy`=1 and `dma_gnt`=0;
  - `mem_*` follow the CPU, so `mem_we` = `cpu_we`.
  - Reset mid-burst drops `dma_gnt` immediately, without waiting for a clock.
  - Release is synchronous to the next `CLK` rising edge.
- **Grant latency**: `dma_req` sampled high at edge n, with `cpu_lock` low, gives `dma_gnt` high from edge n until edge n+1. The same edge drops `cpu_rdy`.
- **Release latency**: `dma_req` low during a DMA cycle gives `cpu_rdy` high from the next edge.
- **Burst limit**: with `dma_req` held high, the pattern repeats as `BURST_MAX` DMA cycles followed by exactly 1 CPU cycle (ST_HOLD).
  - If `cpu_lock` is high in ST_HOLD, the CPU keeps the bus until the lock drops.
  - With `BURST_MAX`=1, DMA and CPU cycles strictly alternate.
- **Simultaneous events**:
  - `dma_req` rising while `cpu_lock` is high: the CPU wins, and the grant is taken on the first edge after `cpu_lock` falls.
  - `dma_req` falling in the same cycle as `bcnt == BURST_MAX`: go to ST_CPU, not ST_HOLD (same observable result, `bcnt` cleared).
- **Ownership vs. write path**: bus ownership changes only on edges. The write path is combinational, so memory sees exactly one master per cycle.

## Structure
- **Shared package** `cpu_pkg`:
  - state encodings ST_CPU/ST_DMA/ST_HOLD, following the `cpu` one-hot parameter style;
  - ADDR_W/DATA_W defaults, shared with `cpu`, `pc` and `MEMORY`.
- **Sub-modules**: none. The FSM, counter and mux live in one module of roughly 150 lines.
- **Assertions**: include an SVA or `initial` check that `BURST_MAX` ≥ 1.

## Test plan
- **Reset**: `R_N`=0 mid-burst (ST_DMA, `bcnt`=2) → `dma_gnt`=0 and `cpu_rdy`=1 before the next edge; after release, `mem_addr` = `cpu_addr` = 0x1234.
- **Single grant**: `dma_req`=1, `dma_we`=1, `dma_addr`=0x0200, `dma_wdata`=0xA5 at edge 0 → `dma_gnt`=1 in cycle 1; memory[0x0200]=0xA5; `dma_req`=0 → `cpu_rdy`=1 at edge 2.
- **Burst cap**: `BURST_MAX`=4 with `dma_req` held → `dma_gnt` pattern 1,1,1,1,0,1,1,1,1,0; a CPU write issued in each gap cycle lands.
- **Lock**: `cpu_lock`=1 for 3 cycles while `dma_req`=1 → `dma_gnt` stays 0 for those 3 cycles and rises on the edge after the lock drops.
- **Drop during DMA**: `dma_req`=0 with `dma_we`=1 inside ST_DMA → `mem_we`=0 that cycle; state is ST_CPU next.
- **`BURST_MAX`=1**: continuous `dma_req` → strict alternation; the CPU completes an LDA #imm in twice the nominal cycles and `reg_a` is correct.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu core, program counter, memory and bus arbiter.
// Holds the bus widths and the one-hot arbiter state encodings.
package cpu_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

   // One-hot so ownership decodes from a single bit (st[1] == DMA).
   typedef enum logic [2:0] {
      ST_CPU  = 3'b001,
      ST_DMA  = 3'b010,
      ST_HOLD = 3'b100
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port memory: CPU vs DMA, with a capped DMA
// burst followed by one guaranteed CPU cycle, and a CPU lock that blocks handover.
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_MAX = 4
) (
   input  logic              CLK,
   input  logic              R_N,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_lock,
   output logic              cpu_rdy,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_we,
   output logic              dma_gnt,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int BW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
   localparam logic [BW-1:0] BCNT_MAX = BW'(BURST_MAX);
   localparam logic [BW-1:0] BCNT_ONE = BW'(1);

   generate
      if (BURST_MAX < 1) begin : g_bad_burst
         $error("mem_arbiter: BURST_MAX must be >= 1");
      end
   endgenerate

   arb_state_e    st;
   logic [BW-1:0] bcnt;

   always_ff @(posedge CLK or negedge R_N) begin
      if (!R_N) begin
         st   <= ST_CPU;
         bcnt <= '0;
      end else begin
         case (st)
            ST_CPU, ST_HOLD: begin
               // HOLD differs from CPU only in that it never lingers.
               if (dma_req && !cpu_lock) begin
                  st   <= ST_DMA;
                  bcnt <= BCNT_ONE;
               end else begin
                  st   <= ST_CPU;
                  bcnt <= '0;
               end
            end
            ST_DMA: begin
               // cpu_lock is ignored here: the CPU is stalled and cannot be mid-sequence.
               if (!dma_req) begin
                  st   <= ST_CPU;
                  bcnt <= '0;
               end else if (bcnt == BCNT_MAX) begin
                  st   <= ST_HOLD;
                  bcnt <= '0;
               end else begin
                  bcnt <= bcnt + BCNT_ONE;
               end
            end
            default: begin
               st   <= ST_CPU;
               bcnt <= '0;
            end
         endcase
      end
   end

   assign dma_gnt = st[1];
   assign cpu_rdy = ~st[1];

   assign mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
   assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
   // A DMA write in the cycle its request drops is dropped with it.
   assign mem_we    = (cpu_rdy & cpu_we) | (dma_gnt & dma_req & dma_we);

   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;

   a_state_onehot : assert property (@(posedge CLK) disable iff (!R_N) $onehot(st))
      else $error("mem_arbiter: state register not one-hot");

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the driver pushes the expected per-cycle bus
// view, a negedge monitor pops and compares. Second instance runs BURST_MAX=1.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        R_N = 1'b1;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_we, cpu_lock;
   logic        dma_req, dma_req1, dma_we;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;

   logic        cpu_rdy0, dma_gnt0, mem_we0;
   logic [7:0]  cpu_rdata0, dma_rdata0, mem_wdata0, mem_rdata0;
   logic [15:0] mem_addr0;

   logic        cpu_rdy1, dma_gnt1, mem_we1;
   logic [7:0]  cpu_rdata1, dma_rdata1, mem_wdata1;
   logic [7:0]  mem_rdata1 = 8'h00;
   logic [15:0] mem_addr1;

   logic [7:0]  mem [0:65535];
   logic        mem_init = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;

   typedef struct {
      int          cyc;
      int          dut;
      logic        gnt;
      logic [15:0] addr;
      logic        we;
      logic [7:0]  wdata;
      string       nm;
   } exp_t;

   exp_t q[$];

   always #5 CLK = ~CLK;

   mem_arbiter #(.ADDR_W(16), .DATA_W(8), .BURST_MAX(4)) u0 (
      .CLK(CLK), .R_N(R_N),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
      .cpu_rdy(cpu_rdy0), .cpu_rdata(cpu_rdata0),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
      .dma_gnt(dma_gnt0), .dma_rdata(dma_rdata0),
      .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0), .mem_rdata(mem_rdata0)
   );

   mem_arbiter #(.ADDR_W(16), .DATA_W(8), .BURST_MAX(1)) u1 (
      .CLK(CLK), .R_N(R_N),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
      .cpu_rdy(cpu_rdy1), .cpu_rdata(cpu_rdata1),
      .dma_req(dma_req1), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
      .dma_gnt(dma_gnt1), .dma_rdata(dma_rdata1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_rdata(mem_rdata1)
   );

   // Memory model behind u0; contents preset to the low address byte.
   always @(posedge CLK) begin
      if (!mem_init) begin
         for (int i = 0; i < 65536; i++) mem[i] <= i[7:0];
         mem_init <= 1'b1;
      end else if (mem_we0) begin
         mem[mem_addr0] <= mem_wdata0;
      end
   end
   assign mem_rdata0 = mem[mem_addr0];

   always @(negedge CLK) begin
      while (q.size() > 0 && q[0].cyc <= cyc_n) begin
         exp_t        e;
         logic        ag, ar, awe;
         logic [15:0] aa;
         logic [7:0]  awd, ard, erd;
         logic        ok;
         e = q.pop_front();
         if (e.dut == 0) begin
            ag = dma_gnt0; ar = cpu_rdy0; aa = mem_addr0; awe = mem_we0; awd = mem_wdata0;
            ard = e.gnt ? dma_rdata0 : cpu_rdata0;
            erd = mem[e.addr];
         end else begin
            ag = dma_gnt1; ar = cpu_rdy1; aa = mem_addr1; awe = mem_we1; awd = mem_wdata1;
            ard = e.gnt ? dma_rdata1 : cpu_rdata1;
            erd = 8'h00;
         end
         ok = (ag === e.gnt) && (ar === ~e.gnt) && (aa === e.addr) && (awe === e.we) &&
              (awd === e.wdata) && (ard === erd);
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got gnt=%b rdy=%b addr=%h we=%b wd=%h rd=%h want gnt=%b rdy=%b addr=%h we=%b wd=%h rd=%h",
                     e.nm, e.dut, e.cyc, ag, ar, aa, awe, awd, ard,
                     e.gnt, ~e.gnt, e.addr, e.we, e.wdata, erd);
         end
      end
   end

   task automatic push_exp(input logic eg, input int d, input string nm);
      exp_t e;
      logic rq;
      rq      = (d == 0) ? dma_req : dma_req1;
      e.cyc   = cyc_n;
      e.dut   = d;
      e.gnt   = eg;
      e.addr  = eg ? dma_addr : cpu_addr;
      e.we    = (!eg && cpu_we) || (eg && rq && dma_we);
      e.wdata = eg ? dma_wdata : cpu_wdata;
      e.nm    = nm;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc_n++;
   endtask

   task automatic cycx(input logic eg, input int d, input string nm);
      push_exp(eg, d, nm);
      tick();
   endtask

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired at cyc=%0d", cyc_n);
      $fatal(1, "timeout");
   end

   initial begin
      int pat_b4 [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      int pat_b1 [6]  = '{0, 1, 0, 1, 0, 1};
      cpu_addr = 16'h1234; cpu_wdata = 8'h00; cpu_we = 1'b0; cpu_lock = 1'b0;
      dma_req = 1'b0; dma_req1 = 1'b0; dma_we = 1'b0;
      dma_addr = 16'h0000; dma_wdata = 8'h00;

      // Reset state
      #1 R_N = 1'b0;
      push_exp(1'b0, 0, "reset");
      push_exp(1'b0, 1, "reset_b1");
      #11 R_N = 1'b1;
      tick();
      cycx(1'b0, 0, "idle_after_rst");

      // Single grant with write, then drop while dma_we still high
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 8'hA5;
      cycx(1'b0, 0, "req_sampled");
      cycx(1'b1, 0, "grant_wr");
      dma_req = 1'b0;
      cycx(1'b1, 0, "drop_we_suppr");
      cycx(1'b0, 0, "release");
      chk8("mem_dma_wr", mem[16'h0200], 8'hA5);
      dma_we = 1'b0;

      // Reset mid-burst (ST_DMA, bcnt=2)
      dma_req = 1'b1;
      cycx(1'b0, 0, "mb_req");
      cycx(1'b1, 0, "mb_dma1");
      R_N = 1'b0; dma_req = 1'b0;
      push_exp(1'b0, 0, "rst_mid_burst");
      #6 R_N = 1'b1;
      tick();
      cycx(1'b0, 0, "post_rst_addr");

      // Burst cap with CPU writes in every CPU-owned cycle
      dma_req = 1'b1; dma_addr = 16'h0400; cpu_we = 1'b1;
      for (int k = 0; k < 11; k++) begin
         cpu_addr  = 16'h0300 + 16'(k);
         cpu_wdata = 8'h10 + 8'(k);
         cycx(pat_b4[k] != 0, 0, "burst_cap");
      end
      cpu_we = 1'b0; cpu_addr = 16'h1234;
      chk8("gap_wr0", mem[16'h0300], 8'h10);
      chk8("gap_wr5", mem[16'h0305], 8'h15);
      chk8("dma_cycle_nowr", mem[16'h0301], 8'h01);

      // Drop in the same cycle bcnt hits the cap
      cycx(1'b1, 0, "cap_dma1");
      cycx(1'b1, 0, "cap_dma2");
      cycx(1'b1, 0, "cap_dma3");
      dma_req = 1'b0;
      cycx(1'b1, 0, "cap_dma4_drop");
      cycx(1'b0, 0, "cap_to_cpu");
      chk8("gap_wr10", mem[16'h030A], 8'h1A);
      cycx(1'b0, 0, "cap_idle");

      // Lock blocks entry for 3 cycles; ignored once in DMA
      dma_req = 1'b1; cpu_lock = 1'b1;
      cycx(1'b0, 0, "lock1");
      cycx(1'b0, 0, "lock2");
      cycx(1'b0, 0, "lock3");
      cpu_lock = 1'b0;
      cycx(1'b0, 0, "lock_drop");
      cpu_lock = 1'b1;
      cycx(1'b1, 0, "lock_in_dma");
      cpu_lock = 1'b0; dma_req = 1'b0;
      cycx(1'b1, 0, "lock_dma2_drop");
      cycx(1'b0, 0, "lock_done");

      // Lock held in the HOLD cycle keeps the CPU on the bus
      dma_req = 1'b1;
      cycx(1'b0, 0, "hl_req");
      for (int k = 0; k < 4; k++) cycx(1'b1, 0, "hl_burst");
      cpu_lock = 1'b1;
      cycx(1'b0, 0, "hl_hold_locked");
      cycx(1'b0, 0, "hl_cpu_locked");
      cpu_lock = 1'b0;
      cycx(1'b0, 0, "hl_unlock");
      dma_req = 1'b0;
      cycx(1'b1, 0, "hl_regrant");
      cycx(1'b0, 0, "hl_idle");

      // BURST_MAX=1: strict alternation; CPU writes visible in each gap
      dma_req1 = 1'b1; dma_we = 1'b1; dma_addr = 16'h0600; dma_wdata = 8'h5A; cpu_we = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cpu_addr  = 16'h0500 + 16'(k);
         cpu_wdata = 8'h20 + 8'(k);
         cycx(pat_b1[k] != 0, 1, "b1_alt");
      end
      dma_req1 = 1'b0;
      cycx(1'b0, 1, "b1_hold_drop");
      cpu_we = 1'b0; dma_we = 1'b0;
      cycx(1'b0, 1, "b1_idle");

      tick();
      tick();
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL queue_drained got=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
